i2s_rx_stream: RTL

I2S_RX_STREAM -- requirements
Module: i2s_rx_stream

---
 rtl/i2s_rx_stream.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_stream.sv
// I2S / left-justified serial audio receiver: captures {left, right} sample pairs
// from a bclk-synchronous stream and delivers them through a first-word-fall-through FIFO.
module i2s_rx_stream #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                               bclk,
   input  logic                               reset,
   input  logic                               lrclk,
   input  logic                               sdata,
   input  logic                               mode,
   input  logic                               enable,
   input  logic                               clr_flags,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [2*SAMPLE_WIDTH-1:0]          out_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic                               overflow,
   output logic                               frame_err
);

   localparam int CW = $clog2(SLOT_WIDTH + 1) + 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int DW = 2 * SAMPLE_WIDTH;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LEFT  = 2'd1;
   localparam logic [1:0] ST_RIGHT = 2'd2;
   localparam logic [1:0] ST_PUSH  = 2'd3;

   logic                    lr_s1_q, lr_s2_q, lr_d3_q, sd_s1_q, sd_s2_q;
   logic [1:0]              state_q, state_d;
   logic                    mode_q, mode_d, mode_eff;
   logic [CW-1:0]           cnt_q, cnt_d, off;
   logic [SAMPLE_WIDTH-1:0] sh_q, sh_d, left_q, left_d;
   logic [DW-1:0]           frame_q, frame_d;
   logic [AW-1:0]           wr_q, rd_q;
   logic [LW-1:0]           level_q, level_d;
   logic                    ovf_q, err_q;
   logic                    fall, rise, edge_det, cap, slot_ok;
   logic                    push, push_ok, pop, full, err_evt, ovf_evt;
   logic [DW-1:0]           mem_q [FIFO_DEPTH];

   // Edges are taken between the second sync stage and one further delay tap.
   assign fall     = lr_d3_q & ~lr_s2_q;
   assign rise     = ~lr_d3_q & lr_s2_q;
   assign edge_det = fall | rise;
   assign slot_ok  = (cnt_q == CW'(SLOT_WIDTH));
   assign mode_eff = (state_q == ST_IDLE) ? mode : mode_q;
   assign mode_d   = mode_eff;
   assign off      = mode_eff ? CW'(0) : CW'(1);
   assign cap      = (cnt_q >= off) && (cnt_q < off + CW'(SAMPLE_WIDTH));

   // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      err_evt = 1'b0;
      push    = 1'b0;
      case (state_q)
         ST_IDLE:  if (fall) state_d = ST_LEFT;
         ST_LEFT:
            if (rise) begin
               if (slot_ok) state_d = ST_RIGHT;
               else begin
                  err_evt = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         ST_RIGHT:
            if (fall) begin
               state_d = ST_LEFT;
               if (slot_ok) begin
                  state_d = ST_PUSH;
                  frame_d = {left_q, sh_q};
               end else begin
                  err_evt = 1'b1;
               end
            end
         ST_PUSH: begin
            push    = 1'b1;
            state_d = ST_LEFT;
            if (rise) begin
               err_evt = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
   end

   always_comb begin
      cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
      sh_d   = sh_q;
      left_d = left_q;
      if (edge_det) begin
         cnt_d = CW'(1);
         sh_d  = mode_eff ? SAMPLE_WIDTH'(sd_s2_q) : '0;
         if (rise) left_d = sh_q;
      end else if (cap) begin
         sh_d = {sh_q[SAMPLE_WIDTH-2:0], sd_s2_q};
      end
   end

   // An empty FIFO forwards the frame being pushed, so out_valid rises during PUSH.
   assign full      = (level_q == LW'(FIFO_DEPTH));
   assign out_valid = (level_q != '0) || (state_q == ST_PUSH);
   assign out_data  = (level_q != '0) ? mem_q[rd_q] :
                      (state_q == ST_PUSH) ? frame_q : '0;
   assign pop       = out_valid & out_ready;
   assign push_ok   = push & (~full | pop);
   assign ovf_evt   = push & full & ~pop;

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge bclk) begin
      if (reset) begin
         lr_s1_q <= 1'b0;
         lr_s2_q <= 1'b0;
         lr_d3_q <= 1'b0;
         sd_s1_q <= 1'b0;
         sd_s2_q <= 1'b0;
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         left_q  <= '0;
         frame_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         lr_s1_q <= lrclk;
         lr_s2_q <= lr_s1_q;
         lr_d3_q <= lr_s2_q;
         sd_s1_q <= sdata;
         sd_s2_q <= sd_s1_q;
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         left_q  <= left_d;
         frame_q <= frame_d;
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         level_q <= level_d;
         ovf_q   <= ovf_evt | (ovf_q & ~clr_flags);
         err_q   <= err_evt | (err_q & ~clr_flags);
      end
   end

   // NOTE: the storage array has no reset; pointers and level define what is valid.
   always_ff @(posedge bclk) begin
      if (push_ok) mem_q[wr_q] <= frame_q;
   end

   assign fifo_level = level_q;
   assign overflow   = ovf_q;
   assign frame_err  = err_q;

endmodule
